ip_tx_arbiter: RTL
==================

// Module: ip_tx_arbiter
// PURPOSE
//  Shares the single IP transmit path between NUM_REQ transport-layer sources (TCP, UDP, ICMP, ...).
//  Grants are round-robin and last for one whole packet. The granted source's word stream
//  (op_st/op/op_end/data) is forwarded with one register stage to the IP header builder.
//  Start timeouts, over-length packets and an inter-packet gap are enforced here.
// PARAMETERS
//  NUM_REQ    3     number of requesters, 2..8
//  MAX_WORDS  375   max 32-bit words per packet (1500 B MTU); a longer packet is truncated
//  START_TO   16    cycles a granted source has to assert op_st before the grant is withdrawn
//  GAP_CYC    2     idle cycles forced between packets on tx side, >=1
// PORTS
//  clk           in   1            system clock
//  rst_n         in   1            asynchronous active-low reset
//  req_i         in   NUM_REQ      source n has a packet ready (level)
//  src_op_st_i   in   NUM_REQ      per-source first-word strobe
//  src_op_i      in   NUM_REQ      per-source word valid
//  src_op_end_i  in   NUM_REQ      per-source last-word strobe
//  src_data_i    in   NUM_REQ*32   per-source data, source n at [32n+31:32n]
//  tx_rdy_i      in   1            downstream can accept a new packet (sampled only in IDLE)
//  gnt_o         out  NUM_REQ      one-hot grant, registered
//  tx_op_st_o    out  1            first word of forwarded packet
//  tx_op_o       out  1            forwarded word valid
//  tx_op_end_o   out  1            last word of forwarded packet
//  tx_data_o     out  32           forwarded data; 0 when tx_op_o=0
//  tx_src_id_o   out  3            index of the granted source, held until the next grant
//  timeout_o     out  1            1-cycle pulse: grant withdrawn, no op_st seen
//  overrun_o     out  1            1-cycle pulse: packet truncated at MAX_WORDS
// BEHAVIOUR
//  Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//   All outputs are 0. FSM goes to IDLE, rr_ptr=NUM_REQ-1, counters are cleared.
//   A reset mid-packet aborts the packet immediately; no tx_op_end_o is emitted.
//  FSM states: IDLE, GRANT, XFER, GAP.
//  IDLE
//   If tx_rdy_i & |req_i: pick the winner as the first set req_i searching upward from rr_ptr+1,
//   wrapping at NUM_REQ. Set gnt_o to that one-hot value and tx_src_id_o to its index next cycle.
//   Clear wait_cnt, go to GRANT. Otherwise stay.
//  GRANT
//   On src_op_st_i[g] & src_op_i[g]: go to XFER, set rr_ptr=g, and forward that word.
//   Else if req_i[g]=0: clear gnt_o, go to IDLE (no pulse).
//   Else if wait_cnt==START_TO-1: pulse timeout_o, clear gnt_o, set rr_ptr=g, go to IDLE.
//   Else wait_cnt++.
//  XFER
//   Each cycle with src_op_i[g]=1 sets tx_op_o=1 and tx_data_o=src data, one cycle later.
//   tx_op_st_o is set on the first word. word_cnt counts forwarded words; the first word counts as 1.
//   src_op_end_i[g] & src_op_i[g]: set tx_op_end_o with that word, clear gnt_o, go to GAP.
//   word_cnt==MAX_WORDS with no end on that word: force tx_op_end_o on it, pulse overrun_o,
//   clear gnt_o, go to GAP. Later words from that source are ignored.
//   Idle cycles (src_op_i[g]=0) inside a packet are passed through as tx_op_o=0. There is no timeout.
//  GAP
//   Wait GAP_CYC cycles with all tx outputs 0, then go to IDLE.
//  Latency is exactly 1 clk from the source strobes to the tx outputs.
//  Strobes from non-granted sources are always ignored.
//  Single-word packet (op_st & op_end in the same cycle): tx_op_st_o and tx_op_end_o are both 1 in one cycle.
//  A src_op_st_i[g] seen during XFER is ignored: no restart, st is not forwarded.
//  Changes to tx_rdy_i outside IDLE do not affect a grant already given.
//  A requester that drops req_i during XFER keeps the grant until end or truncation.
//  rr_ptr advances only on packet start or timeout. A source holding req_i high cannot starve others.
// TESTING
//  1. req_i=3'b001, 4-word packet D0..D3 from src0
//     -> gnt_o=001 one cycle after the request; tx words D0..D3 one cycle after each source word;
//        st on D0, end on D3; gnt_o=0 and GAP lasts 2 cycles.
//  2. req_i=3'b111 held, each source sends 2 words -> packets are served src0, src1, src2, src0.
//     tx_src_id_o follows 0,1,2,0.
//  3. Granted src1 never asserts op_st -> timeout_o pulses 16 cycles after the grant.
//     The next grant goes to src2 when it requests.
//  4. src0 sends 400 words -> word 375 carries tx_op_end_o and overrun_o=1; words 376..400 are dropped.
//  5. Single-word packet 32'hDEADBEEF -> one cycle with st=op=end=1 and tx_data_o=32'hDEADBEEF.
//  6. rst_n asserted at word 3 of 5 -> all outputs 0 asynchronously; after release, FSM is IDLE
//     and src0 wins first.

Source files
------------

// File: rtl/ip_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ip_tx_arbiter
//   Shares the single IP transmit path between NUM_REQ transport-layer
//   sources. Grants are round-robin and cover one whole packet. The granted
//   source's word stream is forwarded to the IP header builder through one
//   register stage. The block also enforces a start timeout, truncates
//   over-length packets, and inserts an inter-packet gap.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   req_i           per-source packet-ready level
//   src_op_st_i     per-source first-word strobe
//   src_op_i        per-source word valid
//   src_op_end_i    per-source last-word strobe
//   src_data_i      per-source data, source n at [32n+31:32n]
//   tx_rdy_i        downstream ready for a new packet (sampled in IDLE only)
//   gnt_o           one-hot registered grant
//   tx_op_st_o      first word of the forwarded packet
//   tx_op_o         forwarded word valid
//   tx_op_end_o     last word of the forwarded packet
//   tx_data_o       forwarded data, 0 when tx_op_o is 0
//   tx_src_id_o     index of the granted source, held until the next grant
//   timeout_o       1-cycle pulse: grant withdrawn because op_st never came
//   overrun_o       1-cycle pulse: packet truncated at MAX_WORDS
// ---------------------------------------------------------------------------
module ip_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned MAX_WORDS = 375,
  parameter int unsigned START_TO  = 16,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    src_op_st_i,
  input  logic [NUM_REQ-1:0]    src_op_i,
  input  logic [NUM_REQ-1:0]    src_op_end_i,
  input  logic [NUM_REQ*32-1:0] src_data_i,
  input  logic                  tx_rdy_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  tx_op_st_o,
  output logic                  tx_op_o,
  output logic                  tx_op_end_o,
  output logic [31:0]           tx_data_o,
  output logic [2:0]            tx_src_id_o,
  output logic                  timeout_o,
  output logic                  overrun_o
);

  localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned TO_W = $clog2(START_TO + 1);
  localparam int unsigned GC_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [GC_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [2:0]         src_id_d;
  logic               tx_st_d, tx_op_d, tx_end_d;
  logic [31:0]        tx_data_d;
  logic               timeout_d, overrun_d;

  // Strobes of the currently granted source
  logic               sel_req, sel_st, sel_op, sel_end;
  logic [31:0]        sel_data;

  // Round-robin winner
  logic               win_found;
  logic [2:0]         win_idx;
  logic [NUM_REQ-1:0] win_onehot;

  // Word handling shared by the first word (GRANT) and the body (XFER)
  logic               first_word, take_word;
  logic [WC_W-1:0]    cnt_now;

  // Source mux driven by the registered grant index; constant-index loop
  // keeps the selection free of variable part-selects.
  always_comb begin
    sel_req  = 1'b0;
    sel_st   = 1'b0;
    sel_op   = 1'b0;
    sel_end  = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (tx_src_id_o == 3'(i)) begin
        sel_req  = req_i[i];
        sel_st   = src_op_st_i[i];
        sel_op   = src_op_i[i];
        sel_end  = src_op_end_i[i];
        sel_data = src_data_i[i*32 +: 32];
      end
    end
  end

  // First requester strictly above rr_ptr, else the first at or below it;
  // equivalent to a wrapping upward search starting at rr_ptr+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_i[j] && (3'(j) > rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_i[j] && (3'(j) <= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(j);
      end
    end
    win_onehot = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      win_onehot[j] = (3'(j) == win_idx);
    end
  end

  always_comb begin
    first_word = (state_q == GRANT) && sel_st && sel_op;
    take_word  = first_word || ((state_q == XFER) && sel_op);
    cnt_now    = first_word ? WC_W'(1) : (word_cnt_q + WC_W'(1));
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    gnt_d      = gnt_o;
    src_id_d   = tx_src_id_o;
    tx_st_d    = 1'b0;
    tx_op_d    = 1'b0;
    tx_end_d   = 1'b0;
    tx_data_d  = '0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_rdy_i && win_found) begin
          gnt_d      = win_onehot;
          src_id_d   = win_idx;
          wait_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (first_word) begin
          rr_ptr_d = tx_src_id_o;
        end else if (!sel_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (wait_cnt_q == TO_W'(START_TO - 1)) begin
          timeout_d = 1'b1;
          gnt_d     = '0;
          rr_ptr_d  = tx_src_id_o;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      XFER: begin
        // Word handling below; a repeated op_st here is simply not forwarded.
      end
      GAP: begin
        if (gap_cnt_q == GC_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A single-word packet starts and ends here in one pass, so the first
    // word goes through the same end/truncation logic as the body words.
    if (take_word) begin
      tx_op_d    = 1'b1;
      tx_st_d    = first_word;
      tx_data_d  = sel_data;
      word_cnt_d = cnt_now;
      if (sel_end || (cnt_now == WC_W'(MAX_WORDS))) begin
        tx_end_d  = 1'b1;
        overrun_d = !sel_end;
        gnt_d     = '0;
        gap_cnt_d = '0;
        state_d   = GAP;
      end else begin
        state_d = XFER;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 3'(NUM_REQ - 1);
      wait_cnt_q  <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      gnt_o       <= '0;
      tx_src_id_o <= '0;
      tx_op_st_o  <= 1'b0;
      tx_op_o     <= 1'b0;
      tx_op_end_o <= 1'b0;
      tx_data_o   <= '0;
      timeout_o   <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      gnt_o       <= gnt_d;
      tx_src_id_o <= src_id_d;
      tx_op_st_o  <= tx_st_d;
      tx_op_o     <= tx_op_d;
      tx_op_end_o <= tx_end_d;
      tx_data_o   <= tx_data_d;
      timeout_o   <= timeout_d;
      overrun_o   <= overrun_d;
    end
  end

endmodule
